// File: rtl/lcd_read_controller.sv
// HD44780 read-cycle engine: single BF/AC or DDRAM read, or busy-flag poll.
// Owns RW/RS/EN and the data bus direction while a read is in flight.
module lcd_read_controller #(
  parameter int CLK_Divide = 16,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int POLL_MAX   = 1000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [7:0] iLCD_DATA,
  output logic [7:0] oData,
  output logic       oDone,
  output logic       oTimeout,
  output logic       oLCD_RD,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EN_HI = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] EN_LAST    = 16'(CLK_Divide);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] POLL_LIM   = 16'(POLL_MAX);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        pre_start;
  logic        poll_q;
  logic [15:0] cnt;
  logic [15:0] attempts;

  logic start_edge;
  logic setup_end;
  logic en_end;
  logic hold_end;
  logic busy;
  logic retry;
  logic give_up;

  assign start_edge = (state == IDLE) & ~pre_start & iStart;
  assign setup_end  = (state == SETUP) & (cnt == SETUP_LAST);
  assign en_end     = (state == EN_HI) & (cnt == EN_LAST);
  assign hold_end   = (state == HOLD) & (cnt == HOLD_LAST);
  assign busy       = poll_q & oData[7];
  assign retry      = busy & (attempts < POLL_LIM);
  assign give_up    = busy & ~retry;

  // Previous iStart level for rising-edge detection.
  always_ff @(posedge iCLK) begin
    if (iRST) pre_start <= 1'b0;
    else      pre_start <= iStart;
  end

  // Next-state decode for the read cycle sequence.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (start_edge) state_nxt = SETUP;
      (state == SETUP): if (setup_end)  state_nxt = EN_HI;
      (state == EN_HI): if (en_end)     state_nxt = HOLD;
      (state == HOLD):  if (hold_end)   state_nxt = CHECK;
      (state == CHECK): state_nxt = retry ? SETUP : DONE;
      (state == DONE):  state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Phase timer, restarted at every phase boundary.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt <= '0;
    end else if (start_edge | setup_end | en_end | hold_end) begin
      cnt <= '0;
    end else if (state == CHECK) begin
      cnt <= '0;
    end else if ((state == SETUP) | (state == EN_HI) | (state == HOLD)) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Mode captured at the accepted start edge.
  always_ff @(posedge iCLK) begin
    if (iRST)            poll_q <= 1'b0;
    else if (start_edge) poll_q <= iPoll;
  end

  // Read attempt counter; saturates at the poll limit.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      attempts <= '0;
    end else if (start_edge) begin
      attempts <= '0;
    end else if (en_end && attempts != POLL_LIM) begin
      attempts <= attempts + 16'd1;
    end
  end

  // Bus sample on the last EN-high cycle.
  always_ff @(posedge iCLK) begin
    if (iRST)        oData <= 8'h00;
    else if (en_end) oData <= iLCD_DATA;
  end

  // Completion and timeout flags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
    end else if (start_edge) begin
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
    end else if (state == CHECK && give_up) begin
      oTimeout <= 1'b1;
    end else if (state == DONE) begin
      oDone    <= 1'b1;
    end
  end

  // Bus ownership, RW and RS: set on accept, released when done.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oLCD_RD <= 1'b0;
      LCD_RW  <= 1'b0;
      LCD_RS  <= 1'b0;
    end else if (start_edge) begin
      oLCD_RD <= 1'b1;
      LCD_RW  <= 1'b1;
      LCD_RS  <= iPoll ? 1'b0 : iRS;
    end else if (state == DONE) begin
      oLCD_RD <= 1'b0;
      LCD_RW  <= 1'b0;
      LCD_RS  <= 1'b0;
    end
  end

  // EN is high exactly for the EN_HI phase.
  always_ff @(posedge iCLK) begin
    if (iRST)           LCD_EN <= 1'b0;
    else if (setup_end) LCD_EN <= 1'b1;
    else if (en_end)    LCD_EN <= 1'b0;
  end

endmodule

// File: tb/tb_lcd_read_controller.sv
// Scoreboard bench for lcd_read_controller with a small LCD response model.
// Stimulus queues expected results; a monitor checks on each oDone rise.
module tb_lcd_read_controller;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iStart;
  logic       iRS;
  logic       iPoll;
  logic [7:0] iLCD_DATA;
  logic [7:0] oData;
  logic       oDone;
  logic       oTimeout;
  logic       oLCD_RD;
  logic       LCD_RW;
  logic       LCD_RS;
  logic       LCD_EN;

  lcd_read_controller #(
    .CLK_Divide(16),
    .SETUP_CYC (2),
    .HOLD_CYC  (2),
    .POLL_MAX  (4)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iStart   (iStart),
    .iRS      (iRS),
    .iPoll    (iPoll),
    .iLCD_DATA(iLCD_DATA),
    .oData    (oData),
    .oDone    (oDone),
    .oTimeout (oTimeout),
    .oLCD_RD  (oLCD_RD),
    .LCD_RW   (LCD_RW),
    .LCD_RS   (LCD_RS),
    .LCD_EN   (LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         pulses;
    int         lat;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic       cur_rs = 1'b0;
  logic [7:0] resp[0:7];
  int         resp_n = 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // LCD model: returns resp[k] for the k-th EN pulse of the transaction.
  int   mcnt = 0;
  logic m_en_prev = 1'b0;
  always @(negedge iCLK) begin
    if (!oLCD_RD) mcnt = 0;
    else if (m_en_prev && !LCD_EN) mcnt++;
    m_en_prev = LCD_EN;
    iLCD_DATA = resp[(mcnt < resp_n) ? mcnt : resp_n - 1];
  end

  // Monitor: bus protocol per EN pulse, scoreboard pop per oDone rise.
  int   enlen = 0;
  int   pulses_seen = 0;
  logic prev_en = 1'b0;
  logic prev_rs = 1'b0;
  logic prev_rw = 1'b0;
  logic prev_done = 1'b0;
  logic rs_at_rise = 1'b0;
  logic moved = 1'b0;
  always @(negedge iCLK) begin
    exp_t e;
    if (iRST) begin
      enlen = 0;
      pulses_seen = 0;
      moved = 1'b0;
    end else begin
      if (LCD_EN && !prev_en) begin
        chk("rs_setup", int'(prev_rs), int'(cur_rs));
        chk("rw_setup", int'(prev_rw), 1);
        chk("rd_owned", int'(oLCD_RD), 1);
        rs_at_rise = LCD_RS;
        moved = 1'b0;
      end
      if (LCD_EN) begin
        enlen++;
        if (LCD_RS !== rs_at_rise || LCD_RW !== 1'b1) moved = 1'b1;
      end
      if (!LCD_EN && prev_en) begin
        chk("en_width", enlen, 17);
        chk("rs_rw_stable", int'(moved), 0);
        chk("rs_hold", int'(LCD_RS), int'(cur_rs));
        enlen = 0;
        pulses_seen++;
      end
      if (oDone && !prev_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("data", int'(oData), int'(e.data));
          chk("timeout", int'(oTimeout), int'(e.to));
          chk("en_pulses", pulses_seen, e.pulses);
          chk("latency", cyc - e.start, e.lat);
          chk("rd_released", int'(oLCD_RD), 0);
          chk("rw_released", int'(LCD_RW), 0);
        end
        pulses_seen = 0;
      end
    end
    prev_en = LCD_EN;
    prev_rs = LCD_RS;
    prev_rw = LCD_RW;
    prev_done = oDone;
  end

  task automatic wait_done(input int n0);
    for (int i = 0; i < 400 && done_cnt == n0; i++) @(negedge iCLK);
    if (done_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no oDone in 400 cycles required one");
    end
    repeat (2) @(negedge iCLK);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic to,
                          input int p, input int lat);
    exp_t e;
    e.data = d;
    e.to = to;
    e.pulses = p;
    e.lat = lat;
    e.start = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic rs, input logic poll, input logic [7:0] d,
                     input logic to, input int p, input int lat);
    int n0;
    n0 = done_cnt;
    iRS = rs;
    iPoll = poll;
    cur_rs = poll ? 1'b0 : rs;
    push_exp(d, to, p, lat);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    wait_done(n0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int ok;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    iRST = 1'b1;
    iStart = 1'b0;
    iRS = 1'b0;
    iPoll = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_en", int'(LCD_EN), 0);
    chk("rst_rd", int'(oLCD_RD), 0);
    chk("rst_rw", int'(LCD_RW), 0);
    chk("rst_done", int'(oDone), 0);
    chk("rst_data", int'(oData), 0);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    resp[0] = 8'h41;
    resp_n = 1;
    run(1'b1, 1'b0, 8'h41, 1'b0, 1, 23);

    resp[0] = 8'h33;
    iRS = 1'b0;
    iPoll = 1'b0;
    cur_rs = 1'b0;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge iCLK);
      if (LCD_EN) ok = 1;
    end
    chk("en_seen_before_reset", ok, 1);
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("midrst_en", int'(LCD_EN), 0);
    chk("midrst_rd", int'(oLCD_RD), 0);
    chk("midrst_done", int'(oDone), 0);
    chk("midrst_data", int'(oData), 0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);

    resp[0] = 8'h25;
    resp_n = 1;
    run(1'b1, 1'b1, 8'h25, 1'b0, 1, 23);

    resp[0] = 8'h80;
    resp[1] = 8'h80;
    resp[2] = 8'h80;
    resp[3] = 8'h07;
    resp_n = 4;
    run(1'b0, 1'b1, 8'h07, 1'b0, 4, 89);

    resp[0] = 8'hC0;
    resp_n = 1;
    run(1'b1, 1'b1, 8'hC0, 1'b1, 4, 89);
    chk("timeout_held", int'(oTimeout), 1);

    resp[0] = 8'h5A;
    resp_n = 1;
    n0 = done_cnt;
    iRS = 1'b1;
    iPoll = 1'b0;
    cur_rs = 1'b1;
    push_exp(8'h5A, 1'b0, 1, 23);
    iStart = 1'b1;
    @(negedge iCLK);
    chk("accept_clr_done", int'(oDone), 0);
    chk("accept_clr_to", int'(oTimeout), 0);
    repeat (9) @(negedge iCLK);
    iStart = 1'b0;
    @(negedge iCLK);
    iStart = 1'b1;
    repeat (89) @(negedge iCLK);
    iStart = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("one_txn", done_cnt - n0, 1);
    chk("done_held", int'(oDone), 1);

    resp[0] = 8'h3C;
    run(1'b0, 1'b0, 8'h3C, 1'b0, 1, 23);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
